// File: rtl/phy_rx_pingpong_ctl.sv
`timescale 1ns/1ps
// RX ping-pong sampler sequencer: alternates samplers A and B through precharge/enable/select
// steps, and runs a per-lane two-pattern data checker during dwell windows.
module phy_rx_pingpong_ctl #(
    parameter int unsigned LANES = 16,
    parameter int unsigned DW    = 32,
    parameter int unsigned CW    = 16,
    parameter int unsigned EW    = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  en,
    input  logic [CW-1:0]         step_cyc,
    input  logic [CW-1:0]         dwell_cyc,
    input  logic                  chk_en,
    input  logic                  clr_err,
    input  logic [DW-1:0]         pat_a,
    input  logic [DW-1:0]         pat_b,
    input  logic [LANES*DW-1:0]   dout,
    output logic                  a_pc,
    output logic                  a_en,
    output logic                  b_pc,
    output logic                  b_en,
    output logic                  sel_a,
    output logic                  busy,
    output logic                  active_a,
    output logic [15:0]           swap_cnt,
    output logic [LANES*EW-1:0]   err_cnt,
    output logic                  err_any
);

    typedef enum logic [3:0] {
        StIdle, StAPcOff, StAOn, StSelA, StBOff, StBPcOn, StDwellA,
        StBPcOff, StBOn, StSelB, StAOff, StAPcOn, StDwellB, StPark, StDrain
    } state_e;

    state_e          state, state_nxt;
    logic [CW-1:0]   tmr;
    logic [CW-1:0]   dur;
    logic [CW-1:0]   dur_load;
    logic            first_dwell;  // next DWELL_A is the first since leaving IDLE
    logic            state_first;  // current cycle is the first one of its state
    logic            chk_now;
    logic [LANES-1:0] mismatch;

    always_comb begin
        state_nxt = state;
        if (state == StIdle) begin
            if (en) state_nxt = StAPcOff;
        end else if (tmr == '0) begin
            case (state)
                StAPcOff: state_nxt = StAOn;
                StAOn:    state_nxt = StSelA;
                StSelA:   state_nxt = StBOff;
                StBOff:   state_nxt = StBPcOn;
                StBPcOn:  state_nxt = StDwellA;
                StDwellA: state_nxt = en ? StBPcOff : StPark;
                StBPcOff: state_nxt = StBOn;
                StBOn:    state_nxt = StSelB;
                StSelB:   state_nxt = StAOff;
                StAOff:   state_nxt = StAPcOn;
                StAPcOn:  state_nxt = StDwellB;
                StDwellB: state_nxt = en ? StAPcOff : StPark;
                StPark:   state_nxt = StDrain;
                StDrain:  state_nxt = StIdle;
                default:  state_nxt = StIdle;
            endcase
        end
    end

    // Timer holds remaining cycles minus one; zero-length settings collapse to one cycle.
    always_comb begin
        dur      = (state_nxt == StDwellA || state_nxt == StDwellB) ? dwell_cyc : step_cyc;
        dur_load = (dur == '0) ? '0 : dur - CW'(1);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= StIdle;
            tmr         <= '0;
            first_dwell <= 1'b0;
            state_first <= 1'b0;
            a_pc        <= 1'b1;
            b_pc        <= 1'b1;
            a_en        <= 1'b0;
            b_en        <= 1'b0;
            sel_a       <= 1'b1;
            busy        <= 1'b0;
            active_a    <= 1'b0;
            swap_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != StIdle);
            active_a    <= (state_nxt == StDwellA);
            state_first <= (state_nxt != state);
            if (state_nxt == state) begin
                if (tmr != '0) tmr <= tmr - CW'(1);
            end else begin
                tmr <= dur_load;
                case (state_nxt)
                    StAPcOff: begin
                        a_pc <= 1'b0;
                        if (state == StIdle) first_dwell <= 1'b1;
                    end
                    StAOn:    a_en  <= 1'b1;
                    StSelA:   sel_a <= 1'b1;
                    StBOff:   b_en  <= 1'b0;
                    StBPcOn:  b_pc  <= 1'b1;
                    StDwellA: begin
                        if (first_dwell) first_dwell <= 1'b0;
                        else             swap_cnt    <= swap_cnt + 16'd1;
                    end
                    StBPcOff: b_pc  <= 1'b0;
                    StBOn:    b_en  <= 1'b1;
                    StSelB:   sel_a <= 1'b0;
                    StAOff:   a_en  <= 1'b0;
                    StAPcOn:  a_pc  <= 1'b1;
                    StDwellB: swap_cnt <= swap_cnt + 16'd1;
                    StPark: begin
                        a_en <= 1'b0;
                        b_en <= 1'b0;
                    end
                    StDrain: begin
                        a_pc  <= 1'b1;
                        b_pc  <= 1'b1;
                        sel_a <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // X/Z on a lane must register as a mismatch, hence the case inequality.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mismatch[i] = (dout[i*DW +: DW] !== pat_a) && (dout[i*DW +: DW] !== pat_b);
        end
    end

    assign chk_now = chk_en && (state == StDwellA || state == StDwellB) && !state_first;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_cnt <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (clr_err) begin
                    err_cnt[i*EW +: EW] <= '0;
                end else if (chk_now && mismatch[i] && (err_cnt[i*EW +: EW] != {EW{1'b1}})) begin
                    err_cnt[i*EW +: EW] <= err_cnt[i*EW +: EW] + EW'(1);
                end
            end
        end
    end

    assign err_any = |err_cnt;

endmodule

// File: doc/phy_rx_pingpong_ctl.md
PHY_RX_PINGPONG_CTL -- requirements
Module: phy_rx_pingpong_ctl

Interface
REQ-001 The block SHALL have parameter LANES, default 16, giving the number of RX data lanes sequenced and checked.
REQ-002 The block SHALL have parameter DW, default 32, giving the per-lane deserialized width.
REQ-003 The block SHALL have parameter CW, default 16, giving the step/dwell counter width.
REQ-004 The block SHALL have parameter EW, default 8, giving the per-lane error counter width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock; rstb  in  1  reset, asserted low.
REQ-006 The block SHALL have the following control inputs:
- en  in  1  run the ping-pong sequence.
- step_cyc  in  CW  cycles per sequencing step.
- dwell_cyc  in  CW  cycles per dwell.
REQ-007 The block SHALL have the following checker inputs:
- chk_en  in  1  enable the data checker.
- clr_err  in  1  synchronous clear of the error counters.
- pat_a  in  DW  first expected word.
- pat_b  in  DW  second expected word.
- dout  in  LANES*DW  packed lane data; lane i occupies bits [i*DW +: DW].
REQ-008 The block SHALL drive the following sampler controls, common to all lanes, valid and clk and rx strobes: a_pc, a_en, b_pc, b_en, sel_a, each out, 1 bit.
REQ-009 The block SHALL provide the following status outputs:
- busy  out  1  FSM is not in IDLE.
- active_a  out  1  sampler A selected and dwelling.
- swap_cnt  out  16  completed A->B or B->A swaps, wrapping.
- err_cnt  out  LANES*EW  per-lane error counts.
- err_any  out  1  OR of all err_cnt fields being nonzero.

Function
REQ-010 The FSM states SHALL be IDLE, A_PCOFF, A_ON, SEL_A, B_OFF, B_PCON, DWELL_A, B_PCOFF, B_ON, SEL_B, A_OFF, A_PCON, DWELL_B, PARK, DRAIN.
REQ-011 Each step state SHALL last max(step_cyc,1) cycles; DWELL_A and DWELL_B SHALL last max(dwell_cyc,1) cycles. Each duration SHALL be latched on state entry; changes mid-state take effect at the next entry.
REQ-012 Output changes on step-state entry SHALL be:
- A_PCOFF: a_pc=0
- A_ON: a_en=1
- SEL_A: sel_a=1
- B_OFF: b_en=0
- B_PCON: b_pc=1
- B_PCOFF: b_pc=0
- B_ON: b_en=1
- SEL_B: sel_a=0
- A_OFF: a_en=0
- A_PCON: a_pc=1
REQ-013 All sampler-control outputs SHALL be registered, and exactly one control bit SHALL change per step transition.
REQ-014 Transitions SHALL follow these rules:
- IDLE->A_PCOFF when en=1.
- The step states SHALL advance in the order of REQ-012: A_PCOFF..B_PCON, then DWELL_A, then B_PCOFF..A_PCON, then DWELL_B, then A_PCOFF.
- At the end of DWELL_A or DWELL_B with en=0, the FSM SHALL go to PARK instead of the next step.
REQ-015 PARK SHALL set a_en=0 and b_en=0 for one step. DRAIN SHALL then set a_pc=1, b_pc=1, sel_a=1 for one step, after which the FSM SHALL return to IDLE.
REQ-016 en SHALL be ignored outside IDLE and dwell ends; deassertion mid-sequence SHALL never leave both samplers enabled-and-unprecharged at rest.
REQ-017 swap_cnt SHALL increment by 1 on each entry to DWELL_A or DWELL_B except the first DWELL_A after IDLE, wrapping 0xFFFF->0.
REQ-018 active_a SHALL be 1 only in DWELL_A, and busy SHALL be 1 in every state except IDLE.
REQ-019 The checker SHALL compare each lane every cycle that chk_en=1 and the FSM is in DWELL_A or DWELL_B, excluding the first dwell cycle.
REQ-020 A lane SHALL be counted as mismatching when dout lane != pat_a and != pat_b; comparison SHALL use 4-state inequality, so X/Z counts as a mismatch.
REQ-021 On a mismatch, the lane's err_cnt SHALL increment by 1, saturating at 2^EW-1.
REQ-022 clr_err=1 SHALL zero all err_cnt fields on the next edge, with priority over a simultaneous increment.
REQ-023 err_any SHALL be combinational from the err_cnt registers.

Reset
REQ-024 While rstb=0, the outputs SHALL be asynchronously forced, with no wait for clk, to:
- FSM=IDLE, a_pc=1, b_pc=1, a_en=0, b_en=0, sel_a=1
- busy=0, active_a=0, swap_cnt=0, err_cnt=0, err_any=0
REQ-025 Reset asserted mid-sequence SHALL yield the same values immediately.
REQ-026 After rstb deasserts, the first state change SHALL occur no earlier than the first clk edge with en=1.

Verification
REQ-027 With step_cyc=4, dwell_cyc=40 and en=1 held, the bench SHALL see: a_pc falls 1 cycle after en; a_en rises 4 cycles later; sel_a, b_en, b_pc follow at 4-cycle spacing; active_a=1 for 40 cycles; then B-side order mirrors it; swap_cnt=2 after the second full cycle begins DWELL_A.
REQ-028 With step_cyc=0 and dwell_cyc=0, every state SHALL last 1 cycle, and one full A+B period SHALL be 12 cycles.
REQ-029 With en dropped during DWELL_B and dwell_cyc=40, the bench SHALL see: dwell completes; then PARK sets a_en=0, b_en=0; then DRAIN sets a_pc=1, b_pc=1, sel_a=1; then IDLE with busy=0 and no further toggling.
REQ-030 With LANES=4, pat_a=32'h55555555, pat_b=32'hAAAAAAAA, lane 2 driven 32'h55555554 for 10 dwell cycles and others correct, the bench SHALL see err_cnt lane2=10, other lanes=0, err_any=1; then clr_err pulsed together with a mismatch SHALL give lane2=0.
REQ-031 With EW=4 and a lane mismatching continuously for 30 checked cycles, that lane's err_cnt SHALL hold at 15.
REQ-032 With rstb pulsed low between clk edges during B_ON, all outputs SHALL immediately take the REQ-024 values, and restart with en=1 SHALL begin again from A_PCOFF.
